// File: rtl/vec_shift_pkg.sv
// Shared types and sizing helpers for the vector round/shift datapath.
// Every width-dependent constant is derived from the instance parameters.
package vec_shift_pkg;

    typedef enum logic [1:0] {
        TRUNC = 2'b00,
        RHU   = 2'b01,
        RHE   = 2'b10,
        RSVD  = 2'b11
    } shift_mode_e;

    typedef enum logic {
        RIGHT = 1'b0,
        LEFT  = 1'b1
    } shift_dir_e;

    localparam int DEF_WIDTH_IN  = 16;
    localparam int DEF_WIDTH_OUT = 16;
    localparam int DEF_SHIFT_W   = 5;
    localparam int DEF_INTER_W   = DEF_WIDTH_IN + (2 ** DEF_SHIFT_W) + 1;

    // Wide enough that a full left shift of any input is exact.
    function automatic int inter_width(input int w_in, input int shift_w);
        return w_in + (2 ** shift_w) + 1;
    endfunction

    function automatic longint sat_max(input int w_out);
        return (longint'(1) << (w_out - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w_out);
        return -(longint'(1) << (w_out - 1));
    endfunction

endpackage

// File: rtl/elem_round_sat.sv
// One element: shift/round into the wide intermediate (feeds S1), and clamp a
// registered intermediate to the output width (feeds S2). Purely combinational.
module elem_round_sat
    import vec_shift_pkg::*;
#(
    parameter int WIDTH_IN  = 16,
    parameter int WIDTH_OUT = 16,
    parameter int SHIFT_W   = 5,
    localparam int IW       = inter_width(WIDTH_IN, SHIFT_W)
) (
    input  logic [WIDTH_IN-1:0]  x_i,
    input  logic [SHIFT_W-1:0]   shamt_i,
    input  shift_dir_e           dir_i,
    input  shift_mode_e          mode_i,
    output logic signed [IW-1:0] inter_o,
    input  logic signed [IW-1:0] inter_i,
    input  shift_dir_e           inter_dir_i,
    output logic [WIDTH_OUT-1:0] y_o,
    output logic                 sat_o
);

    localparam logic signed [IW-1:0] SAT_MAX = IW'(sat_max(WIDTH_OUT));
    localparam logic signed [IW-1:0] SAT_MIN = IW'(sat_min(WIDTH_OUT));

    logic signed [IW-1:0] x_ext;
    logic signed [IW-1:0] floor_val;
    logic signed [IW-1:0] half;
    logic signed [IW-1:0] rhu_sum;
    logic signed [IW-1:0] rhe_sum;

    always_comb begin
        x_ext     = IW'($signed(x_i));
        floor_val = x_ext >>> shamt_i;
        half      = '0;
        if (shamt_i != '0) begin
            half = IW'(1) << (shamt_i - SHIFT_W'(1));
        end
        rhu_sum = x_ext + half;
        // Ties land on the even neighbour: the bias reaches a full half only when the floor is odd.
        rhe_sum = x_ext + half - IW'(1) + IW'(floor_val[0]);

        inter_o = x_ext;
        if (dir_i == LEFT) begin
            inter_o = x_ext <<< shamt_i;
        end else if (shamt_i != '0) begin
            case (mode_i)
                RHU:     inter_o = rhu_sum >>> shamt_i;
                RHE:     inter_o = rhe_sum >>> shamt_i;
                default: inter_o = floor_val;
            endcase
        end
    end

    logic over;
    logic under;
    logic can_sat;

    always_comb begin
        // A right-shifted value never outgrows WIDTH_IN bits, so it only clamps into a narrower output.
        can_sat = (inter_dir_i == LEFT) || (WIDTH_OUT < WIDTH_IN);
        over    = inter_i > SAT_MAX;
        under   = inter_i < SAT_MIN;
        sat_o   = can_sat && (over || under);
        y_o     = inter_i[WIDTH_OUT-1:0];
        if (sat_o) begin
            y_o = over ? SAT_MAX[WIDTH_OUT-1:0] : SAT_MIN[WIDTH_OUT-1:0];
        end
    end

endmodule

// File: rtl/vec_round_shift.sv
// Two-stage vector shifter with rounding and saturation, valid/ready handshake
// and a sticky-at-max saturation beat counter.
module vec_round_shift
    import vec_shift_pkg::*;
#(
    parameter int WIDTH_IN      = 16,
    parameter int WIDTH_OUT     = 16,
    parameter int ELEMS         = 32,
    parameter int TOTAL_INPUT_W = 2,
    parameter int SHIFT_W       = 5,
    parameter int CNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ELEMS*WIDTH_IN-1:0]     in_data [TOTAL_INPUT_W],
    input  logic [SHIFT_W-1:0]            in_shamt,
    input  logic                          in_dir,
    input  logic [1:0]                    in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ELEMS*WIDTH_OUT-1:0]    out_data [TOTAL_INPUT_W],
    output logic                          out_sat,
    output logic [CNT_W-1:0]              sat_count,
    input  logic                          clr_count
);

    localparam int IW = inter_width(WIDTH_IN, SHIFT_W);

    logic signed [IW-1:0]       inter_d [TOTAL_INPUT_W][ELEMS];
    logic signed [IW-1:0]       inter_q [TOTAL_INPUT_W][ELEMS];
    logic [WIDTH_OUT-1:0]       y_w     [TOTAL_INPUT_W][ELEMS];
    logic                       sat_w   [TOTAL_INPUT_W][ELEMS];
    shift_dir_e                 s1_dir_q;
    logic                       s1_vld_q;
    logic                       s2_vld_q;
    logic [ELEMS*WIDTH_OUT-1:0] out_data_d [TOTAL_INPUT_W];
    logic [ELEMS*WIDTH_OUT-1:0] out_data_q [TOTAL_INPUT_W];
    logic                       out_sat_d;
    logic                       out_sat_q;
    logic [CNT_W-1:0]           sat_count_d;
    logic [CNT_W-1:0]           sat_count_q;
    logic                       s1_adv;
    logic                       s2_adv;
    logic                       sat_inc;

    for (genvar v = 0; v < TOTAL_INPUT_W; v++) begin : g_vec
        for (genvar e = 0; e < ELEMS; e++) begin : g_elem
            elem_round_sat #(
                .WIDTH_IN  (WIDTH_IN),
                .WIDTH_OUT (WIDTH_OUT),
                .SHIFT_W   (SHIFT_W)
            ) u_elem (
                .x_i         (in_data[v][(ELEMS-1-e)*WIDTH_IN +: WIDTH_IN]),
                .shamt_i     (in_shamt),
                .dir_i       (shift_dir_e'(in_dir)),
                .mode_i      (shift_mode_e'(in_mode)),
                .inter_o     (inter_d[v][e]),
                .inter_i     (inter_q[v][e]),
                .inter_dir_i (s1_dir_q),
                .y_o         (y_w[v][e]),
                .sat_o       (sat_w[v][e])
            );
        end
    end

    always_comb begin
        out_sat_d = 1'b0;
        for (int v = 0; v < TOTAL_INPUT_W; v++) begin
            out_data_d[v] = '0;
            for (int e = 0; e < ELEMS; e++) begin
                out_data_d[v][(ELEMS-1-e)*WIDTH_OUT +: WIDTH_OUT] = y_w[v][e];
                out_sat_d = out_sat_d | sat_w[v][e];
            end
        end
    end

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = s1_adv;
    assign sat_inc  = s2_vld_q && out_ready && out_sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_dir_q <= RIGHT;
            for (int v = 0; v < TOTAL_INPUT_W; v++) begin
                for (int e = 0; e < ELEMS; e++) begin
                    inter_q[v][e] <= '0;
                end
            end
        end else if (s1_adv) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                s1_dir_q <= shift_dir_e'(in_dir);
                inter_q  <= inter_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld_q  <= 1'b0;
            out_sat_q <= 1'b0;
            for (int v = 0; v < TOTAL_INPUT_W; v++) begin
                out_data_q[v] <= '0;
            end
        end else if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end

    always_comb begin
        sat_count_d = sat_count_q;
        if (clr_count) begin
            sat_count_d = sat_inc ? CNT_W'(1) : '0;
        end else if (sat_inc && !(&sat_count_q)) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_vec_round_shift.sv
// Bench for vec_round_shift: directed corner values plus randomized traffic
// scored against an arithmetic reference model and a counter model.
module tb_vec_round_shift;

    localparam int WI = 16;
    localparam int WO = 16;
    localparam int NE = 32;
    localparam int NV = 2;
    localparam int SW = 5;
    localparam int CW = 16;
    localparam int VW = NE * WO;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_dir, out_valid, out_ready, out_sat, clr_count;
    logic [NE*WI-1:0] in_data [NV];
    logic [SW-1:0]    in_shamt;
    logic [1:0]       in_mode;
    logic [VW-1:0]    out_data [NV];
    logic [CW-1:0]    sat_count;
    logic             in_ready2, out_valid2, out_sat2;
    logic [VW-1:0]    out_data2 [NV];
    logic [1:0]       sat_count2;

    always #5 clk = ~clk;

    vec_round_shift #(
        .WIDTH_IN(WI), .WIDTH_OUT(WO), .ELEMS(NE), .TOTAL_INPUT_W(NV), .SHIFT_W(SW), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_dir(in_dir), .in_mode(in_mode), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .sat_count(sat_count),
        .clr_count(clr_count)
    );

    vec_round_shift #(
        .WIDTH_IN(WI), .WIDTH_OUT(WO), .ELEMS(NE), .TOTAL_INPUT_W(NV), .SHIFT_W(SW), .CNT_W(2)
    ) u_dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_shamt(in_shamt), .in_dir(in_dir), .in_mode(in_mode), .out_valid(out_valid2),
        .out_ready(out_ready), .out_data(out_data2), .out_sat(out_sat2), .sat_count(sat_count2),
        .clr_count(clr_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_out    = 0;
    longint cnt_m  = 0;
    longint cnt2_m = 0;
    logic [NV*VW:0] exp_q [$];
    bit rand_done;

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: exact rational arithmetic on the element value, then clamp.
    function automatic logic [WO:0] ref_elem(input logic [WI-1:0] xb, input int s, input bit left,
                                             input int mode);
        longint x, d, q, r, res;
        logic   sat;
        x = longint'($signed(xb));
        if (left) begin
            res = x * (longint'(1) << s);
        end else if (s == 0) begin
            res = x;
        end else begin
            d = longint'(1) << s;
            q = x / d;
            if (q * d > x) q = q - 1;
            r = x - q * d;
            if (mode == 1)      res = (2 * r >= d) ? q + 1 : q;
            else if (mode == 2) res = (2 * r > d || (2 * r == d && (q % 2) != 0)) ? q + 1 : q;
            else                res = q;
        end
        sat = 1'b0;
        if (res > (longint'(1) << (WO - 1)) - 1) begin res = (longint'(1) << (WO - 1)) - 1; sat = 1'b1; end
        if (res < -(longint'(1) << (WO - 1)))    begin res = -(longint'(1) << (WO - 1));    sat = 1'b1; end
        return {sat, res[WO-1:0]};
    endfunction

    function automatic logic [NV*VW:0] ref_beat();
        logic [NV*VW:0] b;
        logic [WO:0]    r;
        b = '0;
        for (int v = 0; v < NV; v++) begin
            for (int e = 0; e < NE; e++) begin
                r = ref_elem(in_data[v][(NE-1-e)*WI +: WI], int'(in_shamt), in_dir, int'(in_mode));
                b[(NV-1-v)*VW + (NE-1-e)*WO +: WO] = r[WO-1:0];
                b[NV*VW] = b[NV*VW] | r[WO];
            end
        end
        return b;
    endfunction

    always @(negedge clk) begin : mon
        logic [NV*VW:0] h;
        bit inc;
        if (rst) begin
            exp_q.delete();
            cnt_m  = 0;
            cnt2_m = 0;
        end else begin
            check_eq("sat_count", VW'(sat_count), VW'(cnt_m));
            check_eq("sat_count_w2", VW'(sat_count2), VW'(cnt2_m));
            inc = 1'b0;
            h = (exp_q.size() != 0) ? exp_q[0] : '0;
            if (out_valid || out_valid2) begin
                check_eq("out_pending", VW'(exp_q.size() != 0), VW'(1));
                for (int v = 0; v < NV; v++) begin
                    check_eq("out_data", out_data[v], h[(NV-1-v)*VW +: VW]);
                    check_eq("out_data_w2", out_data2[v], h[(NV-1-v)*VW +: VW]);
                end
                check_eq("out_sat", VW'(out_sat), VW'(h[NV*VW]));
                check_eq("out_sat_w2", VW'(out_sat2), VW'(h[NV*VW]));
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    n_out++;
                    inc = h[NV*VW];
                end
            end
            if (clr_count) begin
                cnt_m  = inc ? 1 : 0;
                cnt2_m = inc ? 1 : 0;
            end else if (inc) begin
                if (cnt_m < (longint'(1) << CW) - 1) cnt_m = cnt_m + 1;
                if (cnt2_m < 3) cnt2_m = cnt2_m + 1;
            end
            if (in_valid && in_ready) exp_q.push_back(ref_beat());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input logic [WI-1:0] x);
        for (int v = 0; v < NV; v++)
            for (int e = 0; e < NE; e++) in_data[v][(NE-1-e)*WI +: WI] = x;
    endtask

    task automatic fill_rand();
        for (int v = 0; v < NV; v++)
            for (int e = 0; e < NE; e++) in_data[v][(NE-1-e)*WI +: WI] = WI'($urandom);
    endtask

    task automatic set_ctl(input int s, input bit dir, input int mode);
        in_shamt = SW'(s);
        in_dir   = dir;
        in_mode  = 2'(mode);
    endtask

    task automatic send();
        int n;
        n = 0;
        in_valid = 1'b1;
        @(negedge clk);
        while (!(in_ready && in_ready2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("send_ready", VW'(in_ready), VW'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        check_eq("drain", VW'(exp_q.size()), VW'(0));
    endtask

    task automatic directed(input string tag, input logic [WI-1:0] x, input int s, input bit dir,
                            input int mode, input logic [WO-1:0] ey, input bit esat);
        int lat;
        fill_const(x);
        set_ctl(s, dir, mode);
        send();
        wait_out(lat);
        check_eq({tag, "_lat"}, VW'(lat), VW'(2));
        check_eq({tag, "_y0"}, VW'(out_data[0][VW-1 -: WO]), VW'(ey));
        check_eq({tag, "_ylast"}, VW'(out_data[NV-1][WO-1:0]), VW'(ey));
        check_eq({tag, "_sat"}, VW'(out_sat), VW'(esat));
        drain();
    endtask

    task automatic pulse_clr();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int lat;
        int base;
        bit saw_stall;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr_count = 1'b0;
        set_ctl(0, 1'b0, 0);
        fill_const('0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", VW'(out_valid), VW'(0));
        check_eq("rst_out_sat", VW'(out_sat), VW'(0));
        check_eq("rst_sat_count", VW'(sat_count), VW'(0));
        check_eq("rst_out_data", out_data[0], VW'(0));
        check_eq("rst_in_ready", VW'(in_ready), VW'(1));
        rst = 1'b0;
        tick();

        directed("trunc_fff0", 16'hFFF0, 4, 1'b0, 0, 16'hFFFF, 1'b0);
        directed("rhu_0018",   16'h0018, 4, 1'b0, 1, 16'h0002, 1'b0);
        directed("rhe_0018",   16'h0018, 4, 1'b0, 2, 16'h0002, 1'b0);
        directed("rhe_0028",   16'h0028, 4, 1'b0, 2, 16'h0002, 1'b0);
        directed("rhu_0028",   16'h0028, 4, 1'b0, 1, 16'h0003, 1'b0);
        directed("trunc_fff8", 16'hFFF8, 4, 1'b0, 0, 16'hFFFF, 1'b0);
        directed("rhu_fff8",   16'hFFF8, 4, 1'b0, 1, 16'h0000, 1'b0);
        directed("rhe_fff8",   16'hFFF8, 4, 1'b0, 2, 16'h0000, 1'b0);
        directed("rsvd_fff0",  16'hFFF0, 4, 1'b0, 3, 16'hFFFF, 1'b0);
        directed("lsh_4000",   16'h4000, 1, 1'b1, 0, 16'h7FFF, 1'b1);
        directed("lsh_8000",   16'h8000, 1, 1'b1, 2, 16'h8000, 1'b1);
        directed("trunc_s20",  16'h8000, 20, 1'b0, 0, 16'hFFFF, 1'b0);
        directed("rhe_s20",    16'h8000, 20, 1'b0, 2, 16'h0000, 1'b0);
        directed("rhu_s20",    16'h8000, 20, 1'b0, 1, 16'h0000, 1'b0);
        directed("pass_r_s0",  16'h1234, 0, 1'b0, 1, 16'h1234, 1'b0);
        directed("pass_l_s0",  16'h8765, 0, 1'b1, 2, 16'h8765, 1'b0);

        // Counter: 3 saturating + 2 clean beats.
        pulse_clr();
        check_eq("cnt_cleared", VW'(sat_count), VW'(0));
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin fill_const(16'h4000); set_ctl(1, 1'b1, 0); end
            else       begin fill_const(16'h0001); set_ctl(0, 1'b0, 0); end
            send();
        end
        drain();
        check_eq("cnt_three", VW'(sat_count), VW'(3));
        check_eq("cnt_three_w2", VW'(sat_count2), VW'(3));

        // Clear coinciding with a saturating output handshake.
        fill_const(16'h4000);
        set_ctl(1, 1'b1, 0);
        send();
        wait_out(lat);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        check_eq("cnt_clr_inc", VW'(sat_count), VW'(1));
        check_eq("cnt_clr_inc_w2", VW'(sat_count2), VW'(1));
        drain();
        for (int i = 0; i < 5; i++) send();
        drain();
        check_eq("cnt_six", VW'(sat_count), VW'(6));
        check_eq("cnt_hold_w2", VW'(sat_count2), VW'(3));

        // Per-beat control alternation.
        for (int i = 0; i < 9; i++) begin
            fill_rand();
            case (i % 3)
                0:       set_ctl(1, 1'b0, $urandom_range(0, 3));
                1:       set_ctl(2, 1'b1, $urandom_range(0, 3));
                default: set_ctl(15, 1'b0, $urandom_range(0, 3));
            endcase
            send();
        end
        drain();

        // Backpressure: 8 incrementing beats, out_ready low on cycles 3-6.
        base = n_out;
        saw_stall = 1'b0;
        set_ctl(1, 1'b0, 1);
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    fill_const(WI'(16'h0100 + i));
                    send();
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                repeat (14) begin
                    @(negedge clk);
                    if (!in_ready) saw_stall = 1'b1;
                end
            end
        join
        drain();
        check_eq("bp_in_ready_fell", VW'(saw_stall), VW'(1));
        check_eq("bp_beat_count", VW'(n_out - base), VW'(8));

        // Randomized traffic with random backpressure and occasional clears.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    fill_rand();
                    set_ctl(($urandom_range(0, 1) == 0) ? $urandom_range(0, 4) : $urandom_range(0, 31),
                            1'($urandom_range(0, 1)), $urandom_range(0, 3));
                    clr_count = ($urandom_range(0, 15) == 0);
                    send();
                    clr_count = 1'b0;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight.
        fill_const(16'h4000);
        set_ctl(1, 1'b1, 0);
        send();
        send();
        check_eq("mid_inflight", VW'(out_valid), VW'(1));
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", VW'(out_valid), VW'(0));
        check_eq("mid_rst_count", VW'(sat_count), VW'(0));
        check_eq("mid_rst_in_ready", VW'(in_ready), VW'(1));
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check_eq("post_rst_idle", VW'(out_valid), VW'(0));
        directed("post_rst", 16'h0040, 2, 1'b0, 0, 16'h0010, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vec_round_shift.md
# vec_round_shift

Parametrised, pipelined vector shifter for the self-attention datapath. It applies a runtime-selected arithmetic shift to every fixed-point element of `TOTAL_INPUT_W` packed vectors, with selectable rounding and output saturation. It uses a valid/ready handshake and counts saturation events. It replaces the fixed 4-bit right-shift stage wherever a scale step (for example a 1/sqrt(d_k) approximation or a requantise) sits between the MAC arrays and softmax.

## Interface
Parameters:
- `WIDTH_IN`, 16: signed element width on input.
- `WIDTH_OUT`, 16: signed element width on output.
- `ELEMS`, 32: elements per vector. Equals CHUNK_SIZE*NUM_CORES_A*NUM_CORES_B*TOTAL_MODULES at instantiation.
- `TOTAL_INPUT_W`, 2: number of vectors per beat.
- `SHIFT_W`, 5: width of the shift amount.
- `CNT_W`, 16: width of the saturation counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: block accepts a beat this cycle.
- `in_data`, input, [ELEMS*WIDTH_IN-1:0] x TOTAL_INPUT_W: element 0 sits at the MSBs.
- `in_shamt`, input, SHIFT_W: shift amount, sampled with the beat.
- `in_dir`, input, 1: 0 selects right shift, 1 selects left shift.
- `in_mode`, input, 2: 00 truncate (floor), 01 round-half-up, 10 round-half-even, 11 treated as 00.
- `out_valid`, output, 1: output beat valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_data`, output, [ELEMS*WIDTH_OUT-1:0] x TOTAL_INPUT_W: same element order as `in_data`.
- `out_sat`, output, 1: at least one element of this beat saturated.
- `sat_count`, output, CNT_W: count of accepted output beats with `out_sat`=1.
- `clr_count`, input, 1: synchronous clear of `sat_count`.

## Operation
Per element x (signed WIDTH_IN), with s = `in_shamt`:
- **Right shift.** Truncate gives floor(x/2^s). Round-half-up adds 2^(s-1) before `>>>`. Round-half-even adds 2^(s-1)-1+LSB(x>>>s). s=0 passes x through unchanged in every mode.
- **Left shift.** x*2^s computed exactly. `in_mode` is ignored.
- **Intermediate width.** WIDTH_IN+2^SHIFT_W+1 bits, so nothing is lost before saturation.
- **Large right shifts (s >= WIDTH_IN).** Truncate gives -1 for x<0 and 0 otherwise. Both rounding modes give 0.
- **Saturation.** The result is clamped to the signed WIDTH_OUT range [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]. `out_sat` is the OR of the per-element clamp flags over all vectors of the beat.
- **Saturation counter.** `sat_count` increments when `out_valid && out_ready && out_sat`. It holds at all-ones and never wraps.
  - `clr_count` alone sets it to 0.
  - `clr_count` together with an increment sets it to 1.

## Timing
- **Pipeline.** Two stages.
  - S1 registers the shifted and rounded intermediate together with the shift direction.
  - S2 registers the saturated `out_data` and `out_sat`.
- **Latency.** Input handshake to `out_valid` is 2 cycles. Throughput is 1 beat per cycle while `out_ready`=1.
- **Backpressure.** `in_ready` = !(S1 valid && S2 valid && !out_ready). It is combinational from `out_ready` and the registered valids.
  - A stage advances when it is empty or the stage downstream of it advances.
  - While `out_valid && !out_ready`, `out_data` and `out_sat` hold stable.
  - No beat is dropped or duplicated.
- **Sampling.** `in_shamt`, `in_dir` and `in_mode` are captured per beat, so they may change every cycle.
- **Reset values** (all asynchronous on `rst`):
  - `out_valid`=0, `out_data`=0, `out_sat`=0, `sat_count`=0.
  - Both stage valids are 0.
  - While `rst`=1, `in_ready` reads 1 but no beat is accepted.
- **Reset mid-stream.** In-flight beats are discarded. The first beat after deassertion appears 2 cycles after its handshake.

## Structure
- **Package `vec_shift_pkg`:**
  - `shift_mode_e` enum: TRUNC, RHU, RHE, RSVD.
  - `shift_dir_e` enum: RIGHT, LEFT.
  - Localparams for the intermediate width, and sat max/min as functions of WIDTH_OUT.
- **Sub-module `elem_round_sat`.** Combinational and instantiated ELEMS*TOTAL_INPUT_W times. It takes one element, s, dir and mode, and returns the saturated value plus a sat flag. The shift/round part feeds S1 and the clamp part feeds S2. The top level holds the pipeline registers, the handshake and the counter.

## Test plan
Defaults apply (WIDTH_IN=WIDTH_OUT=16), with `out_ready`=1 unless stated.
- **Rounding modes.** Right shift s=4:
  - x=0xFFF0: TRUNC gives 0xFFFF.
  - x=0x0018: RHU gives 0x0002, RHE gives 0x0002.
  - x=0x0028: RHE gives 0x0002, RHU gives 0x0003.
  - x=0xFFF8: TRUNC gives 0xFFFF, RHU gives 0x0000, RHE gives 0x0000.
  - All results appear 2 cycles after the handshake.
- **Saturation and limits.**
  - Left shift s=1 of 0x4000 gives 0x7FFF with `out_sat`=1. Left shift s=1 of 0x8000 gives 0x8000 with `out_sat`=1.
  - Right shift s=20 of 0x8000: TRUNC gives 0xFFFF, RHE gives 0x0000.
  - s=0 passes through unchanged with `out_sat`=0.
- **Backpressure.** Stream 8 beats with incrementing data, holding `out_ready`=0 on cycles 3-6.
  - `in_ready` falls once both stages are full.
  - The output sequence is exactly 8 beats, in order, with no drops or duplicates.
  - `out_data` is stable while stalled.
- **Per-beat control.** Alternate `in_dir` and `in_shamt` every cycle: (R,1), (L,2), (R,15). Each output matches the control sampled with its own beat.
- **Counter.**
  - 3 saturating beats plus 2 clean beats give `sat_count`=3.
  - `clr_count` coincident with a saturating handshake gives 1.
  - Forcing CNT_W=2 with 5 saturating beats holds the count at 3.
- **Reset mid-stream.** Assert `rst` with 2 beats in flight.
  - `out_valid`=0 immediately and `sat_count`=0.
  - After release, a new beat appears with 2-cycle latency and no stale data.
